// File: rtl/uart_tx_core.sv
// uart_tx_core: UART transmitter with a one-entry holding register.
//
// A payload word and its frame options are taken from the data source
// into a holding register. The control FSM moves the held word into the
// active frame on a baud TICK and shifts it out on TX_OUT:
// start bit, data bits LSB first, optional parity bit, then one or two
// stop bits.
//
// Handshake: a transfer happens on a CLK edge where DATA_VALID && DATA_READY.
// DATA_READY is high only while the holding register is empty. DATA_VALID
// while DATA_READY is low is ignored, and the held word is never
// overwritten. The source may change P_DATA, DATA_VALID and the option bits
// freely at any other time.
//
// Ports:
//   CLK        system clock; all logic on posedge
//   RST        synchronous active-high reset
//   TICK       baud strobe, one CLK wide, once per bit period
//   P_DATA     parallel payload (DATA_WIDTH bits)
//   DATA_VALID payload valid
//   DATA_READY holding register empty
//   PAR_EN     parity bit enable, sampled with the payload
//   PAR_TYP    0 = even parity, 1 = odd parity, sampled with the payload
//   STOP2      1 = two stop bits, sampled with the payload
//   TX_OUT     registered serial line, idles high
//   BUSY       frame in flight or pending
//   DBG_STATE  current FSM state (encoding of state_t)

module uart_tx_core #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = $clog2(DATA_WIDTH)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  TICK,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    output logic                  DATA_READY,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    output logic                  TX_OUT,
    output logic                  BUSY,
    output logic [2:0]            DBG_STATE
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP1  = 3'd4,
        S_STOP2  = 3'd5
    } state_t;

    // Holding register
    logic [DATA_WIDTH-1:0] r_hold_data;
    logic                  r_hold_par_en;
    logic                  r_hold_par_typ;
    logic                  r_hold_stop2;
    logic                  r_pending;

    // Active frame
    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_par_en;
    logic                  r_stop2;
    logic                  r_parity;
    logic                  r_tx;
    logic                  r_busy;

    logic w_accept;
    logic w_final_stop;
    logic w_load;
    logic w_to_idle;
    logic w_pending_next;
    logic w_busy_next;

    assign w_accept     = DATA_VALID && !r_pending;
    // The last stop bit of the frame: STOP1 when one stop bit, else STOP2.
    assign w_final_stop = (r_state == S_STOP1 && !r_stop2) || (r_state == S_STOP2);
    // Loading from the final stop state chains frames with no idle bit.
    assign w_load       = TICK && r_pending && ((r_state == S_IDLE) || w_final_stop);
    assign w_to_idle    = ((r_state == S_IDLE) && !w_load)
                       || (TICK && w_final_stop && !r_pending);
    assign w_pending_next = w_accept ? 1'b1 : (w_load ? 1'b0 : r_pending);
    // BUSY tracks the next-cycle state/pending so it lines up with them.
    assign w_busy_next  = !w_to_idle || w_pending_next;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_hold_data    <= '0;
            r_hold_par_en  <= 1'b0;
            r_hold_par_typ <= 1'b0;
            r_hold_stop2   <= 1'b0;
            r_pending      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_hold_data    <= P_DATA;
                r_hold_par_en  <= PAR_EN;
                r_hold_par_typ <= PAR_TYP;
                r_hold_stop2   <= STOP2;
            end
            r_pending <= w_pending_next;
        end
    end

    // Control FSM; TX_OUT is set to the value of the state being entered,
    // so each bit lasts exactly one TICK period.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_shift  <= '0;
            r_cnt    <= '0;
            r_par_en <= 1'b0;
            r_stop2  <= 1'b0;
            r_parity <= 1'b0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
        end else begin
            r_busy <= w_busy_next;
            if (w_load) begin
                r_state  <= S_START;
                r_tx     <= 1'b0;
                r_shift  <= r_hold_data;
                r_cnt    <= '0;
                r_par_en <= r_hold_par_en;
                r_stop2  <= r_hold_stop2;
                r_parity <= r_hold_par_typ ? ~^r_hold_data : ^r_hold_data;
            end else if (TICK) begin
                case (r_state)
                    S_IDLE: begin
                        r_tx <= 1'b1;
                    end
                    S_START: begin
                        r_state <= S_DATA;
                        r_cnt   <= '0;
                        r_tx    <= r_shift[0];
                    end
                    S_DATA: begin
                        r_shift <= r_shift >> 1;
                        r_cnt   <= r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                            if (r_par_en) begin
                                r_state <= S_PARITY;
                                r_tx    <= r_parity;
                            end else begin
                                r_state <= S_STOP1;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_tx <= r_shift[1];
                        end
                    end
                    S_PARITY: begin
                        r_state <= S_STOP1;
                        r_tx    <= 1'b1;
                    end
                    S_STOP1: begin
                        r_state <= r_stop2 ? S_STOP2 : S_IDLE;
                        r_tx    <= 1'b1;
                    end
                    S_STOP2: begin
                        r_state <= S_IDLE;
                        r_tx    <= 1'b1;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_tx    <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign DATA_READY = !r_pending;
    assign TX_OUT     = r_tx;
    assign BUSY       = r_busy;
    assign DBG_STATE  = r_state;

endmodule

// File: tb/tb_uart_tx_core.sv
module tb_uart_tx_core;

    logic       CLK;
    logic       RST;
    logic       TICK;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       DATA_READY;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       STOP2;
    logic       TX_OUT;
    logic       BUSY;
    logic [2:0] DBG_STATE;

    int n_cmp;
    int n_err;
    bit tick_en;
    int tick_div;
    int tick_cnt;

    uart_tx_core #(.DATA_WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .TICK       (TICK),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .DATA_READY (DATA_READY),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .STOP2      (STOP2),
        .TX_OUT     (TX_OUT),
        .BUSY       (BUSY),
        .DBG_STATE  (DBG_STATE)
    );

    // Clock
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Baud strobe: one CLK wide, every tick_div cycles, changed away from edges
    initial begin
        TICK     = 1'b0;
        tick_cnt = 0;
        forever begin
            @(posedge CLK);
            #2;
            tick_cnt++;
            TICK = tick_en && ((tick_cnt % tick_div) == 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Offer one word; returns once it has been accepted (or the budget ran out).
    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic s2);
        bit ok;
        ok = 1'b0;
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        STOP2      = s2;
        DATA_VALID = 1'b1;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (DATA_READY === 1'b1) ok = 1'b1;
            @(posedge CLK);
            #1;
        end
        DATA_VALID = 1'b0;
        // Scramble the inputs; the accepted frame must not follow them.
        P_DATA  = ~d;
        PAR_EN  = ~pe;
        PAR_TYP = ~pt;
        STOP2   = ~s2;
        check("send_accepted", 32'(ok), 32'd1);
    endtask

    // Sample TX_OUT after each of the next n TICK edges (bit k = k-th sample).
    task automatic capture(input int n, output logic [31:0] v, output logic busy_all,
                           output logic last_busy, output logic saw_s2);
        bit got;
        v         = '0;
        busy_all  = 1'b1;
        last_busy = 1'b0;
        saw_s2    = 1'b0;
        for (int k = 0; k < n; k++) begin
            got = 1'b0;
            for (int c = 0; c < 200 && !got; c++) begin
                @(posedge CLK);
                if (TICK === 1'b1) got = 1'b1;
            end
            if (!got) begin
                n_cmp++;
                n_err++;
                $display("FAIL tick_wait: got no TICK expected TICK within 200 cycles");
                return;
            end
            #1;
            v[k] = TX_OUT;
            if (DBG_STATE == 3'd5) saw_s2 = 1'b1;
            if (k < n - 1) begin
                if (BUSY !== 1'b1) busy_all = 1'b0;
            end else begin
                last_busy = BUSY;
            end
        end
    endtask

    typedef struct {
        logic [7:0]  data;
        logic        par_en;
        logic        par_typ;
        logic        stop2;
        int          nbits;
        logic [11:0] bits;   // bit k = k-th transmitted bit, start bit first
        int          div;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [31:0] cap;
        logic [31:0] exp_v;
        logic        busy_all;
        logic        last_busy;
        logic        saw_s2;
        bit          quiet;

        n_cmp      = 0;
        n_err      = 0;
        tick_en    = 1'b0;
        tick_div   = 4;
        RST        = 1'b1;
        P_DATA     = '0;
        DATA_VALID = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        STOP2      = 1'b0;

        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 10, 12'h34A, 4};
        vecs[1] = '{8'hA5, 1'b1, 1'b0, 1'b0, 11, 12'h54A, 4};
        vecs[2] = '{8'hA5, 1'b1, 1'b1, 1'b0, 11, 12'h74A, 4};
        vecs[3] = '{8'h00, 1'b1, 1'b1, 1'b1, 12, 12'hE00, 4};
        vecs[4] = '{8'hFF, 1'b0, 1'b0, 1'b1, 11, 12'h7FE, 4};
        vecs[5] = '{8'h3C, 1'b1, 1'b0, 1'b0, 11, 12'h478, 4};
        vecs[6] = '{8'h01, 1'b1, 1'b0, 1'b0, 11, 12'h602, 4};
        vecs[7] = '{8'hA5, 1'b0, 1'b0, 1'b0, 10, 12'h34A, 1};
        vecs[8] = '{8'h96, 1'b1, 1'b1, 1'b1, 12, 12'hF2C, 2};

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        check("rst_tx_out", 32'(TX_OUT), 32'd1);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_ready", 32'(DATA_READY), 32'd1);
        check("rst_state", 32'(DBG_STATE), 32'd0);
        RST     = 1'b0;
        tick_en = 1'b1;
        repeat (10) @(posedge CLK);
        #1;
        check("idle_tick_tx", 32'(TX_OUT), 32'd1);
        check("idle_tick_busy", 32'(BUSY), 32'd0);

        // Single frames from the table
        foreach (vecs[i]) begin
            tick_div = vecs[i].div;
            send(vecs[i].data, vecs[i].par_en, vecs[i].par_typ, vecs[i].stop2);
            check("accept_ready_low", 32'(DATA_READY), 32'd0);
            check("accept_busy_high", 32'(BUSY), 32'd1);
            capture(vecs[i].nbits + 1, cap, busy_all, last_busy, saw_s2);
            exp_v = 32'(vecs[i].bits) | (32'd1 << vecs[i].nbits);
            check("frame_bits", cap, exp_v);
            check("frame_busy", 32'(busy_all), 32'd1);
            check("frame_end_busy", 32'(last_busy), 32'd0);
            check("stop2_state_seen", 32'(saw_s2), 32'(vecs[i].stop2));
            check("frame_end_ready", 32'(DATA_READY), 32'd1);
        end

        // Back-to-back: 0x55 then 0x0F offered as soon as the holding register frees
        tick_div = 4;
        send(8'h55, 1'b0, 1'b0, 1'b0);
        fork
            capture(21, cap, busy_all, last_busy, saw_s2);
            send(8'h0F, 1'b0, 1'b0, 1'b0);
        join
        check("b2b_bits", cap, 32'h2AA | (32'h21E << 10) | (32'd1 << 20));
        check("b2b_busy", 32'(busy_all), 32'd1);
        check("b2b_end_busy", 32'(last_busy), 32'd0);

        // Holding register full: 0xFF offered while not ready must be dropped
        tick_en = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        send(8'hC3, 1'b0, 1'b0, 1'b0);
        P_DATA     = 8'hFF;
        PAR_EN     = 1'b1;
        STOP2      = 1'b1;
        DATA_VALID = 1'b1;
        repeat (5) @(posedge CLK);
        #1;
        check("hold_ready_low", 32'(DATA_READY), 32'd0);
        DATA_VALID = 1'b0;
        tick_en    = 1'b1;
        capture(11, cap, busy_all, last_busy, saw_s2);
        check("hold_bits", cap, 32'h786);
        check("hold_end_busy", 32'(last_busy), 32'd0);
        check("hold_end_ready", 32'(DATA_READY), 32'd1);

        // Reset during data bit 3 with a second frame pending
        tick_div = 4;
        send(8'hA5, 1'b0, 1'b0, 1'b0);
        fork
            capture(5, cap, busy_all, last_busy, saw_s2);
            send(8'h0F, 1'b0, 1'b0, 1'b0);
        join
        check("pre_rst_bits", cap, 32'h0A);
        check("pre_rst_ready", 32'(DATA_READY), 32'd0);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        check("mid_rst_tx", 32'(TX_OUT), 32'd1);
        check("mid_rst_busy", 32'(BUSY), 32'd0);
        check("mid_rst_ready", 32'(DATA_READY), 32'd1);
        check("mid_rst_state", 32'(DBG_STATE), 32'd0);
        quiet = 1'b1;
        repeat (40) begin
            @(posedge CLK);
            #1;
            if (TX_OUT !== 1'b1 || BUSY !== 1'b0) quiet = 1'b0;
        end
        check("post_rst_quiet", 32'(quiet), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
